// File: rtl/key_sequence_player.sv
// Replays a latched passcode onto the lock key bus as timed press/release events.
// Define KEY_SEQUENCE_PLAYER_REPEAT_ENTRY_EN to play the code twice (enter+confirm).
module key_sequence_player #(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int PASSCODE_LENGTH = 4,
  parameter int PASSCODE_WIDTH  = 4*PASSCODE_LENGTH,
  parameter int PRESS_CYCLES    = CLOCK_FREQ/20,
  parameter int RELEASE_CYCLES  = CLOCK_FREQ/20,
  parameter int TIMER_WIDTH     =
    $clog2((PRESS_CYCLES > RELEASE_CYCLES ?
            PRESS_CYCLES : RELEASE_CYCLES) + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PASSCODE_WIDTH-1:0] code,
  output logic [3:0]                key,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int CW = $clog2(PASSCODE_LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(PASSCODE_LENGTH - 1);
  localparam logic [TIMER_WIDTH-1:0] P_END =
    TIMER_WIDTH'(PRESS_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] R_END =
    TIMER_WIDTH'(RELEASE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T_ONE = TIMER_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, CHECK, PRESS, RELEASE, FINISH
  } state_t;

  state_t                    state_q;
  logic [PASSCODE_WIDTH-1:0] shift_q;
  logic [PASSCODE_WIDTH-1:0] shifted;
  logic [TIMER_WIDTH-1:0]    timer_q;
  logic [CW-1:0]             cnt_q;
  logic [3:0]                key_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      error_q;
  logic                      has_zero;
`ifdef KEY_SEQUENCE_PLAYER_REPEAT_ENTRY_EN
  logic [PASSCODE_WIDTH-1:0] orig_q;
  logic                      pass_q;
`endif

  assign shifted = shift_q << 4;

  always_comb begin
    has_zero = 1'b0;
    for (int i = 0; i < PASSCODE_LENGTH; i++)
      if (shift_q[4*i +: 4] == 4'h0) has_zero = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      key_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef KEY_SEQUENCE_PLAYER_REPEAT_ENTRY_EN
      orig_q  <= '0;
      pass_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          key_q <= 4'h0;
          if (start) begin
            shift_q <= code;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
`ifdef KEY_SEQUENCE_PLAYER_REPEAT_ENTRY_EN
            orig_q  <= code;
            pass_q  <= 1'b0;
`endif
          end
        end
        CHECK: begin
          // Rejection also completes through FINISH: done lands 2 edges after accept
          if (has_zero) begin
            error_q <= 1'b1;
            state_q <= FINISH;
          end else begin
            key_q   <= shift_q[PASSCODE_WIDTH-1 -: 4];
            timer_q <= '0;
            cnt_q   <= '0;
            state_q <= PRESS;
          end
        end
        PRESS: begin
          if (timer_q == P_END) begin
            key_q   <= 4'h0;
            timer_q <= '0;
            state_q <= RELEASE;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        RELEASE: begin
          if (timer_q == R_END) begin
            timer_q <= '0;
            if (cnt_q == LAST) begin
`ifdef KEY_SEQUENCE_PLAYER_REPEAT_ENTRY_EN
              if (!pass_q) begin
                pass_q  <= 1'b1;
                shift_q <= orig_q;
                cnt_q   <= '0;
                key_q   <= orig_q[PASSCODE_WIDTH-1 -: 4];
                state_q <= PRESS;
              end else begin
                state_q <= FINISH;
              end
`else
              state_q <= FINISH;
`endif
            end else begin
              shift_q <= shifted;
              cnt_q   <= cnt_q + CW'(1);
              key_q   <= shifted[PASSCODE_WIDTH-1 -: 4];
              state_q <= PRESS;
            end
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key   = key_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_key_sequence_player.sv
// Directed bench for key_sequence_player with short press/release timings.
// Covers basic play, zero-digit rejection, ignored start and async reset.
module tb_key_sequence_player;

  localparam int P = 3;
  localparam int R = 2;
`ifdef KEY_SEQUENCE_PLAYER_REPEAT_ENTRY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] code  = 16'h0;
  logic [3:0]  key;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  logic ab;

  key_sequence_player #(
    .PASSCODE_LENGTH(4),
    .PRESS_CYCLES(P),
    .RELEASE_CYCLES(R)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .code(code),
    .key(key),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // inj: step at which start/code=FFFF is re-driven; rst_at: step for reset
  task automatic play(input logic [15:0] c, input int inj,
                      input int rst_at, output logic aborted);
    int step;
    logic [3:0] exp;
    aborted = 1'b0;
    start = 1'b1;
    code  = c;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_key", key, 0);
    chk("accept_err", error, 0);
    step = 0;
    for (int p = 0; p < PASSES; p++)
      for (int d = 0; d < 4; d++)
        for (int j = 0; j < P + R; j++) begin
          @(negedge clock);
          exp = (j < P) ? c[15-4*d -: 4] : 4'h0;
          chk("key", key, exp);
          chk("busy_run", busy, 1);
          chk("done_run", done, 0);
          if (step == inj) begin
            start = 1'b1;
            code  = 16'hFFFF;
          end else if (step == inj + 1) begin
            start = 1'b0;
          end
          if (step == rst_at) begin
            reset = 1'b1;
            #1;
            chk("rst_key", key, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            @(negedge clock);
            reset = 1'b0;
            aborted = 1'b1;
            return;
          end
          step++;
        end
    @(negedge clock);
    chk("pre_done", done, 0);
    @(negedge clock);
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_err", error, 0);
    chk("done_key", key, 0);
    @(negedge clock);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    #1;
    chk("reset_key", key, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", error, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic play
    play(16'h8148, -10, -10, ab);
    @(negedge clock);

    // Zero digit: rejected, error sticky
    start = 1'b1;
    code  = 16'h8108;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("zero_busy", busy, 1);
    @(negedge clock);
    chk("zero_err_set", error, 1);
    chk("zero_done_early", done, 0);
    chk("zero_key1", key, 0);
    @(negedge clock);
    chk("zero_done", done, 1);
    chk("zero_busy_end", busy, 0);
    chk("zero_key2", key, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("zero_done_low", done, 0);
      chk("zero_err_hold", error, 1);
      chk("zero_key_idle", key, 0);
    end
    play(16'h1234, -10, -10, ab);
    @(negedge clock);

    // Start re-asserted during digit-2 press is ignored
    play(16'h8148, 6, -10, ab);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("single_done", done, 0);
      chk("idle_busy", busy, 0);
    end

    // Reset during digit-3 press, then a clean run
    play(16'h8148, -10, 11, ab);
    chk("rst_aborted", ab, 1);
    @(negedge clock);
    chk("post_rst_key", key, 0);
    chk("post_rst_busy", busy, 0);
    play(16'h2222, -10, -10, ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
